// File: rtl/switch_mcu_regfile.sv
// ---------------------------------------------------------------------------
// switch_mcu_regfile
//
// Purpose:
//   32 x 32-bit register file with two independent registered read ports and
//   one write port. Entry x0 is hard-wired to zero. Writes to x0 are dropped.
//   Read data appears one cycle after the request, with a one-cycle valid
//   pulse. When a port is idle, its data output keeps its last value.
//
// Ports:
//   in_clk        : system clock. All state changes on the rising edge.
//   in_rst        : synchronous, active-low reset.
//   in_ren_1      : read request, port 1.
//   in_raddr_1    : read index, port 1 (5 bits).
//   out_rdata_1   : registered read data, port 1 (32 bits).
//   out_rvalid_1  : one-cycle pulse that marks fresh data on port 1.
//   in_ren_2      : read request, port 2.
//   in_raddr_2    : read index, port 2 (5 bits).
//   out_rdata_2   : registered read data, port 2 (32 bits).
//   out_rvalid_2  : one-cycle pulse that marks fresh data on port 2.
//   in_wen        : write strobe.
//   in_waddr      : write index (5 bits).
//   in_wdata      : write data (32 bits).
//
// Build option:
//   SWITCH_MCU_RF_BYPASS_EN
//     Defined     : a read and a write to the same nonzero index on the same
//                   edge returns in_wdata (write-through forwarding).
//     Not defined : the same collision returns the value stored before the
//                   write. The new value is visible from the next read on.
// ---------------------------------------------------------------------------
module switch_mcu_regfile (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_ren_1,
  input  logic [4:0]  in_raddr_1,
  output logic [31:0] out_rdata_1,
  output logic        out_rvalid_1,
  input  logic        in_ren_2,
  input  logic [4:0]  in_raddr_2,
  output logic [31:0] out_rdata_2,
  output logic        out_rvalid_2,
  input  logic        in_wen,
  input  logic [4:0]  in_waddr,
  input  logic [31:0] in_wdata
);

  // x0 has no storage. It is decoded as a constant zero on the read side.
  logic [31:0] r_mem [1:31];

  logic [31:0] r_rdata1;
  logic [31:0] r_rdata2;
  logic        r_rvalid1;
  logic        r_rvalid2;

  logic        w_wrAccept;
  logic [31:0] w_stored1;
  logic [31:0] w_stored2;
  logic [31:0] w_rdNext1;
  logic [31:0] w_rdNext2;

  // A write takes effect only when it targets x1..x31.
  assign w_wrAccept = in_wen && (in_waddr != 5'd0);

  // Array lookup for each port. Index 0 always reads zero, whatever was
  // written to it.
  always_comb begin
    w_stored1 = 32'h0;
    w_stored2 = 32'h0;
    if (in_raddr_1 != 5'd0) w_stored1 = r_mem[in_raddr_1];
    if (in_raddr_2 != 5'd0) w_stored2 = r_mem[in_raddr_2];
  end

`ifdef SWITCH_MCU_RF_BYPASS_EN
  // Forward the incoming write data when it targets the index being read.
  // w_wrAccept already excludes x0, so x0 still reads zero.
  always_comb begin
    w_rdNext1 = w_stored1;
    w_rdNext2 = w_stored2;
    if (w_wrAccept && (in_waddr == in_raddr_1)) w_rdNext1 = in_wdata;
    if (w_wrAccept && (in_waddr == in_raddr_2)) w_rdNext2 = in_wdata;
  end
`else
  // No forwarding. The array is read before the non-blocking write lands,
  // so a colliding read returns the old contents.
  always_comb begin
    w_rdNext1 = w_stored1;
    w_rdNext2 = w_stored2;
  end
`endif

  // Storage update. Reset clears every writable entry. A write arriving
  // during reset is dropped.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      for (int i = 1; i < 32; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_wrAccept) begin
      r_mem[in_waddr] <= in_wdata;
    end
  end

  // Read port 1. The valid pulse follows the request by one edge. The data
  // register loads only on a request, so it holds between requests.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      r_rdata1  <= 32'h0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid1 <= in_ren_1;
      if (in_ren_1) r_rdata1 <= w_rdNext1;
    end
  end

  // Read port 2. Same behaviour as port 1, with fully independent state.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      r_rdata2  <= 32'h0;
      r_rvalid2 <= 1'b0;
    end else begin
      r_rvalid2 <= in_ren_2;
      if (in_ren_2) r_rdata2 <= w_rdNext2;
    end
  end

  assign out_rdata_1  = r_rdata1;
  assign out_rvalid_1 = r_rvalid1;
  assign out_rdata_2  = r_rdata2;
  assign out_rvalid_2 = r_rvalid2;

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// ---------------------------------------------------------------------------
// tb_switch_mcu_regfile
//
// Self-checking bench for switch_mcu_regfile. Directed scenarios come first,
// then a randomized run. Every cycle is compared against a reference model
// that keeps the register contents in a plain array.
// ---------------------------------------------------------------------------
module tb_switch_mcu_regfile;

  logic        clock;
  logic        rstN;
  logic        ren1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        rvalid1;
  logic        ren2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        rvalid2;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, plus the expected output values.
  logic [31:0] refMem [0:31];
  logic [31:0] expData1;
  logic [31:0] expData2;
  logic        expValid1;
  logic        expValid2;

  switch_mcu_regfile dut (
    .in_clk       (clock),
    .in_rst       (rstN),
    .in_ren_1     (ren1),
    .in_raddr_1   (raddr1),
    .out_rdata_1  (rdata1),
    .out_rvalid_1 (rvalid1),
    .in_ren_2     (ren2),
    .in_raddr_2   (raddr2),
    .out_rdata_2  (rdata2),
    .out_rvalid_2 (rvalid2),
    .in_wen       (wen),
    .in_waddr     (waddr),
    .in_wdata     (wdata)
  );

  // 10 ns period clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // What a read of index a returns if it shares an edge with the given
  // write. Index 0 reads zero. On a collision, the build option decides
  // between the new data and the old contents.
  function automatic logic [31:0] modelRead(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef SWITCH_MCU_RF_BYPASS_EN
    if (we && (wa == a)) return wd;
`endif
    return refMem[a];
  endfunction

  // Compare all four outputs with the model after the edge has settled.
  task automatic checkOutput(input string tag);
    checks++;
    assert (rvalid1 === expValid1) else begin
      errors++;
      $error("[TB] FAIL %s rvalid_1 observed=%b expected=%b", tag, rvalid1, expValid1);
    end
    checks++;
    assert (rdata1 === expData1) else begin
      errors++;
      $error("[TB] FAIL %s rdata_1 observed=%h expected=%h", tag, rdata1, expData1);
    end
    checks++;
    assert (rvalid2 === expValid2) else begin
      errors++;
      $error("[TB] FAIL %s rvalid_2 observed=%b expected=%b", tag, rvalid2, expValid2);
    end
    checks++;
    assert (rdata2 === expData2) else begin
      errors++;
      $error("[TB] FAIL %s rdata_2 observed=%h expected=%h", tag, rdata2, expData2);
    end
  endtask

  // Drive one cycle of inputs, update the model for that edge, then clock
  // the DUT and check it 1 ns after the edge.
  task automatic applyStimulus(input string tag, input logic rst,
                               input logic r1, input logic [4:0] a1,
                               input logic r2, input logic [4:0] a2,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] wd);
    rstN = rst; ren1 = r1; raddr1 = a1; ren2 = r2; raddr2 = a2;
    wen = we; waddr = wa; wdata = wd;
    if (!rst) begin
      for (int i = 0; i < 32; i++) refMem[i] = 32'h0;
      expData1 = 32'h0; expData2 = 32'h0;
      expValid1 = 1'b0; expValid2 = 1'b0;
    end else begin
      expValid1 = r1;
      expValid2 = r2;
      if (r1) expData1 = modelRead(a1, we, wa, wd);
      if (r2) expData2 = modelRead(a2, we, wa, wd);
      if (we && (wa != 5'd0)) refMem[wa] = wd;
    end
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic        rr;
    logic        r1;
    logic        r2;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  wa;
    logic [31:0] wd;

    rstN = 1'b0; ren1 = 1'b0; raddr1 = '0; ren2 = 1'b0; raddr2 = '0;
    wen = 1'b0; waddr = '0; wdata = '0;
    for (int i = 0; i < 32; i++) refMem[i] = 32'h0;
    expData1 = '0; expData2 = '0; expValid1 = 1'b0; expValid2 = 1'b0;

    // Reset state.
    applyStimulus("reset0", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    applyStimulus("reset1", 1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd5, 32'hAAAA5555);

    // First edge after reset: read x5 on port 1 and x0 on port 2.
    applyStimulus("postRstRead", 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0);

    // Write x7, read it on both ports, then go idle so data is held.
    applyStimulus("wrX7", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF);
    applyStimulus("rdX7", 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    applyStimulus("holdX7", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

    // A write to x0 is ignored.
    applyStimulus("wrX0", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h12345678);
    applyStimulus("rdX0", 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0);

    // Same-edge write and read of x3, then a read on the next cycle.
    applyStimulus("preX3", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h11111111);
    applyStimulus("collideX3", 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd3, 32'h22222222);
    applyStimulus("afterX3", 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);

    // A read issued during reset gives no valid, and reset clears x31.
    applyStimulus("wrX31", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31, 32'hFFFFFFFF);
    applyStimulus("rstRdX31", 1'b0, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    applyStimulus("relRdX31", 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

    // Back-to-back reads of x1, x2 and x3 on port 1.
    applyStimulus("ld1", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 32'd1);
    applyStimulus("ld2", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 32'd2);
    applyStimulus("ld3", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'd3);
    applyStimulus("b2b1", 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    applyStimulus("b2b2", 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    applyStimulus("b2b3", 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    applyStimulus("b2bIdle", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

    // Randomized traffic. Indices are often confined to 0..7 so that
    // collisions and x0 accesses happen often. Reset is asserted now and then.
    for (int n = 0; n < 400; n++) begin
      rr = ($urandom_range(0, 49) != 0);
      r1 = $urandom_range(0, 1) == 1;
      r2 = $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 1) == 1) begin
        a1 = 5'($urandom_range(0, 7));
        a2 = 5'($urandom_range(0, 7));
        wa = 5'($urandom_range(0, 7));
      end else begin
        a1 = 5'($urandom_range(0, 31));
        a2 = 5'($urandom_range(0, 31));
        wa = 5'($urandom_range(0, 31));
      end
      wd = $urandom;
      applyStimulus("random", rr, r1, a1, r2, a2, we, wa, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
